parking_sensor_frontend: RTL and testbench

//  Upstream conditioning stage for the parking gate controller. Synchronises and debounces the raw

---
 rtl/parking_sensor_frontend.sv | 180 ++++++++++++++++++
 tb/tb_parking_sensor_frontend.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/parking_sensor_frontend.sv
// ---------------------------------------------------------------------------
// parking_sensor_frontend
//
// Conditioning stage in front of the parking gate controller. Three raw,
// asynchronous, possibly bouncing sensors (entrance, gate-exit, lot-leave)
// are synchronised and debounced. The clean entrance/gate-exit levels go to
// the gate FSM. Rising edges of the debounced gate-exit and lot-leave levels
// drive a saturating occupancy counter. Arrivals can be masked while the lot
// is full, and sticky flags record attempted over/underflows.
//
// Ports
//   clk              in   1      system clock, everything on posedge
//   reset_n          in   1      synchronous active-low reset
//   raw_entrance     in   1      raw car-at-entrance sensor
//   raw_exit         in   1      raw car-cleared-gate sensor (car entered lot)
//   raw_leave        in   1      raw lot-egress sensor (car left lot)
//   err_clr          in   1      one-cycle pulse clearing the sticky errors
//   sensor_entrance  out  1      debounced entrance level, masked when full
//   sensor_exit      out  1      debounced gate-exit level
//   car_in_pulse     out  1      1-cycle strobe per debounced exit rise
//   car_out_pulse    out  1      1-cycle strobe per debounced leave rise
//   occupancy        out  CNT_W  cars currently in the lot
//   lot_full         out  1      occupancy == CAPACITY
//   lot_empty        out  1      occupancy == 0
//   err_overflow     out  1      sticky: car_in seen while full
//   err_underflow    out  1      sticky: car_out seen while empty
// ---------------------------------------------------------------------------
module parking_sensor_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CAPACITY        = 8,
  parameter int CNT_W           = 4,
  parameter int BLOCK_WHEN_FULL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw_entrance,
  input  logic             raw_exit,
  input  logic             raw_leave,
  input  logic             err_clr,
  output logic             sensor_entrance,
  output logic             sensor_exit,
  output logic             car_in_pulse,
  output logic             car_out_pulse,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty,
  output logic             err_overflow,
  output logic             err_underflow
);

  // Channel indices into the per-sensor vectors.
  localparam int CH_ENT   = 0;
  localparam int CH_EXIT  = 1;
  localparam int CH_LEAVE = 2;
  localparam int NCH      = 3;

  // The debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(CAPACITY);
  localparam logic            MASK_EN = (BLOCK_WHEN_FULL != 0);

  logic [NCH-1:0]  raw;
  logic [NCH-1:0]  sync_p0;
  logic [NCH-1:0]  sync_p1;
  logic [NCH-1:0]  deb_p2;
  logic [DB_W-1:0] db_cnt_p2 [NCH];
  logic [CH_LEAVE:CH_EXIT] deb_d_p3;

  logic            rise_in;
  logic            rise_out;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_next;
  logic            ovf_set;
  logic            unf_set;
  logic            pin_q;
  logic            pout_q;
  logic            ovf_q;
  logic            unf_q;

  assign raw = {raw_leave, raw_exit, raw_entrance};

  // ---- stage p0/p1: two-flop synchroniser ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: debouncer ----
  // A differing synchronised level must persist for DEBOUNCE_CYCLES cycles
  // in a row; any return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      deb_p2 <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        db_cnt_p2[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (sync_p1[ch] == deb_p2[ch]) begin
          db_cnt_p2[ch] <= '0;
        end else if (db_cnt_p2[ch] == DB_LAST) begin
          deb_p2[ch]    <= sync_p1[ch];
          db_cnt_p2[ch] <= '0;
        end else begin
          db_cnt_p2[ch] <= db_cnt_p2[ch] + DB_W'(1);
        end
      end
    end
  end

  // ---- stage p3: edge detection, pulses, occupancy ----
  // Only the exit and leave channels feed the counter, so only they are delayed.
  assign rise_in  = deb_p2[CH_EXIT]  & ~deb_d_p3[CH_EXIT];
  assign rise_out = deb_p2[CH_LEAVE] & ~deb_d_p3[CH_LEAVE];

  // Simultaneous arrival and departure cancel, so the count holds without
  // error even at full or empty.
  always_comb begin
    occ_next = occ_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (rise_in && !rise_out) begin
      if (occ_q == OCC_MAX) begin
        ovf_set = 1'b1;
      end else begin
        occ_next = occ_q + CNT_W'(1);
      end
    end else if (rise_out && !rise_in) begin
      if (occ_q == '0) begin
        unf_set = 1'b1;
      end else begin
        occ_next = occ_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      deb_d_p3 <= '0;
      pin_q    <= 1'b0;
      pout_q   <= 1'b0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      deb_d_p3 <= deb_p2[CH_LEAVE:CH_EXIT];
      pin_q    <= rise_in;
      pout_q   <= rise_out;
      occ_q    <= occ_next;
      // A new error in the same cycle as err_clr must survive the clear.
      if (err_clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign lot_full        = (occ_q == OCC_MAX);
  assign lot_empty       = (occ_q == '0);
  assign sensor_entrance = deb_p2[CH_ENT] & ~(MASK_EN & lot_full);
  assign sensor_exit     = deb_p2[CH_EXIT];
  assign car_in_pulse    = pin_q;
  assign car_out_pulse   = pout_q;
  assign occupancy       = occ_q;
  assign err_overflow    = ovf_q;
  assign err_underflow   = unf_q;

endmodule

// File: tb/tb_parking_sensor_frontend.sv
module tb_parking_sensor_frontend;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       raw_entrance, raw_exit, raw_leave, err_clr;
  logic       sensor_entrance, sensor_exit, car_in_pulse, car_out_pulse;
  logic [3:0] occupancy;
  logic       lot_full, lot_empty, err_overflow, err_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  parking_sensor_frontend #(
    .DEBOUNCE_CYCLES(4),
    .CAPACITY(8),
    .CNT_W(4),
    .BLOCK_WHEN_FULL(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_entrance(raw_entrance),
    .raw_exit(raw_exit),
    .raw_leave(raw_leave),
    .err_clr(err_clr),
    .sensor_entrance(sensor_entrance),
    .sensor_exit(sensor_exit),
    .car_in_pulse(car_in_pulse),
    .car_out_pulse(car_out_pulse),
    .occupancy(occupancy),
    .lot_full(lot_full),
    .lot_empty(lot_empty),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // flags order: sensor_entrance, sensor_exit, car_in, car_out, full, empty, ovf, unf
  typedef struct {
    string      name;
    logic       e, x, l, clr;
    int         cyc;
    logic [7:0] flags;
    int         occ;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic e, x, l, clr, input int cyc,
                     input logic s_e, s_x, pin, pout, input int occ,
                     input logic full, empty, ovf, unf);
    vec_t v;
    v.name = n; v.e = e; v.x = x; v.l = l; v.clr = clr; v.cyc = cyc;
    v.flags = {s_e, s_x, pin, pout, full, empty, ovf, unf};
    v.occ = occ;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [7:0] want_flags, input int want_occ);
    logic [7:0] got;
    got = {sensor_entrance, sensor_exit, car_in_pulse, car_out_pulse,
           lot_full, lot_empty, err_overflow, err_underflow};
    n_tests++;
    if (got !== want_flags || int'(occupancy) != want_occ) begin
      n_fail++;
      $display("FAIL %s: flags(se,sx,in,out,full,empty,ovf,unf) got %b want %b, occupancy got %0d want %0d",
               n, got, want_flags, occupancy, want_occ);
    end
  endtask

  initial begin
    // Stimulus table, applied in order from the post-reset state.
    add("idle",      0,0,0,0, 1, 0,0,0,0, 0, 0,1,0,0);
    // entrance latency: 6 posedges
    add("ent_5",     1,0,0,0, 5, 0,0,0,0, 0, 0,1,0,0);
    add("ent_6",     1,0,0,0, 1, 1,0,0,0, 0, 0,1,0,0);
    add("ent_fall",  0,0,0,0, 7, 0,0,0,0, 0, 0,1,0,0);
    // short excursion is filtered
    add("glitch_hi", 0,1,0,0, 3, 0,0,0,0, 0, 0,1,0,0);
    add("glitch_lo", 0,0,0,0, 8, 0,0,0,0, 0, 0,1,0,0);
    // underflow and clear
    add("unf_rise",  0,0,1,0, 7, 0,0,0,1, 0, 0,1,0,1);
    add("unf_fall",  0,0,0,0, 7, 0,0,0,0, 0, 0,1,0,1);
    add("unf_clr",   0,0,0,1, 1, 0,0,0,0, 0, 0,1,0,0);
    add("clr_off",   0,0,0,0, 1, 0,0,0,0, 0, 0,1,0,0);
    // fill the lot
    for (int i = 1; i <= 8; i++) begin
      add($sformatf("pass_in%0d", i),  0,1,0,0, 7, 0,1,1,0, i, (i == 8), 0,0,0);
      add($sformatf("pass_out%0d", i), 0,0,0,0, 7, 0,0,0,0, i, (i == 8), 0,0,0);
    end
    add("full_mask", 1,0,0,0, 7, 0,0,0,0, 8, 1,0,0,0);
    add("ovf_in",    1,1,0,0, 7, 0,1,1,0, 8, 1,0,1,0);
    add("ovf_out",   0,0,0,0, 7, 0,0,0,0, 8, 1,0,1,0);
    add("ovf_clr",   0,0,0,1, 1, 0,0,0,0, 8, 1,0,0,0);
    add("clr_off2",  0,0,0,0, 1, 0,0,0,0, 8, 1,0,0,0);
    // drain to 3
    for (int i = 7; i >= 3; i--) begin
      add($sformatf("leave_in%0d", i),  0,0,1,0, 7, 0,0,0,1, i, 0,0,0,0);
      add($sformatf("leave_out%0d", i), 0,0,0,0, 7, 0,0,0,0, i, 0,0,0,0);
    end
    // simultaneous in/out cancel
    add("both_in",   0,1,1,0, 7, 0,1,1,1, 3, 0,0,0,0);
    add("both_out",  0,0,0,0, 7, 0,0,0,0, 3, 0,0,0,0);
    // back up to 5 for the reset case
    for (int i = 4; i <= 5; i++) begin
      add($sformatf("pre_in%0d", i),  0,1,0,0, 7, 0,1,1,0, i, 0,0,0,0);
      add($sformatf("pre_out%0d", i), 0,0,0,0, 7, 0,0,0,0, i, 0,0,0,0);
    end

    // Power-on reset.
    reset_n = 1'b0; raw_entrance = 1'b0; raw_exit = 1'b0; raw_leave = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    check("reset", 8'b0000_0100, 0);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      raw_entrance = vecs[k].e;
      raw_exit     = vecs[k].x;
      raw_leave    = vecs[k].l;
      err_clr      = vecs[k].clr;
      for (int c = 0; c < vecs[k].cyc; c++) tick();
      check(vecs[k].name, vecs[k].flags, vecs[k].occ);
    end

    // Mid-operation reset while raw_exit is partway through debounce.
    raw_exit = 1'b1;
    tick(); tick(); tick();
    check("pre_reset", 8'b0000_0000, 5);
    reset_n = 1'b0;
    tick();
    check("mid_reset", 8'b0000_0100, 0);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("rst_lat5", 8'b0000_0100, 0);
    tick();
    check("rst_lat6", 8'b0100_0100, 0);
    tick();
    check("rst_pulse", 8'b0110_0000, 1);
    tick();
    check("rst_pulse_end", 8'b0100_0000, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
